// File: rtl/icache_mem_ctrl.sv
// Direct-mapped instruction cache: combinational hit path plus a blocking
// single-miss fill controller on the Icache port of the memory arbiter.
`ifndef XLEN
`define XLEN 32
`endif

module icache_mem_ctrl #(
  parameter int NUM_LINES = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [`XLEN-1:0]  proc2Icache_addr,
  input  logic              proc2Icache_valid,
  output logic [63:0]       Icache_data_out,
  output logic              Icache_valid_out,
  output logic [`XLEN-1:0]  Icache2mem_addr,
  output logic [1:0]        Icache2mem_command,
  input  logic [3:0]        mem2Icache_response,
  input  logic [3:0]        mem2Icache_tag,
  input  logic [63:0]       mem2Icache_data
);

  localparam int IDX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS = `XLEN - 3 - IDX_BITS;
  localparam logic [1:0] BUS_NONE = 2'h0;
  localparam logic [1:0] BUS_LOAD = 2'h1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t               state_reg, state_next;
  logic [`XLEN-4:0]     miss_line_reg, miss_line_next;
  logic [3:0]           saved_tag_reg, saved_tag_next;

  logic [63:0]          line_data [NUM_LINES];
  logic [TAG_BITS-1:0]  line_tag  [NUM_LINES];
  logic [NUM_LINES-1:0] line_valid_reg;
  logic [NUM_LINES-1:0] line_we;

  logic [IDX_BITS-1:0]  fetch_idx, miss_idx;
  logic [TAG_BITS-1:0]  fetch_tag, miss_tag;
  logic                 hit, fill_en;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^proc2Icache_addr[2:0];

  assign fetch_idx = proc2Icache_addr[3 +: IDX_BITS];
  assign fetch_tag = proc2Icache_addr[`XLEN-1 -: TAG_BITS];
  assign miss_idx  = miss_line_reg[IDX_BITS-1:0];
  assign miss_tag  = miss_line_reg[`XLEN-4 -: TAG_BITS];

  assign hit = proc2Icache_valid && line_valid_reg[fetch_idx] &&
               (line_tag[fetch_idx] == fetch_tag);
  assign Icache_valid_out = hit;
  assign Icache_data_out  = hit ? line_data[fetch_idx] : 64'd0;

  // Tag 0 means "no data this cycle"; other tags belong to the Dcache.
  assign fill_en = (state_reg == WAIT) && (mem2Icache_tag != 4'd0) &&
                   (mem2Icache_tag == saved_tag_reg);

  generate
    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line_we
      assign line_we[gi] = fill_en && (miss_idx == IDX_BITS'(gi));
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (fill_en) begin
      line_data[miss_idx] <= mem2Icache_data;
      line_tag[miss_idx]  <= miss_tag;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      line_valid_reg <= '0;
    end else begin
      line_valid_reg <= line_valid_reg | line_we;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      miss_line_reg <= '0;
      saved_tag_reg <= 4'd0;
    end else begin
      state_reg     <= state_next;
      miss_line_reg <= miss_line_next;
      saved_tag_reg <= saved_tag_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    miss_line_next = miss_line_reg;
    saved_tag_next = saved_tag_reg;
    case (state_reg)
      IDLE: begin
        if (proc2Icache_valid && !hit) begin
          miss_line_next = proc2Icache_addr[`XLEN-1:3];
          state_next     = REQ;
        end
      end
      REQ: begin
        // A zero response is an arbiter rejection; the request is simply reissued.
        if (mem2Icache_response != 4'd0) begin
          saved_tag_next = mem2Icache_response;
          state_next     = WAIT;
        end
      end
      WAIT: begin
        if (fill_en) begin
          saved_tag_next = 4'd0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Icache2mem_command = BUS_NONE;
    Icache2mem_addr    = '0;
    if (state_reg == REQ) begin
      Icache2mem_command = BUS_LOAD;
      Icache2mem_addr    = {miss_line_reg, 3'b000};
    end
  end

endmodule

// File: tb/tb_icache_mem_ctrl.sv
// Directed bench for icache_mem_ctrl: fills, arbiter rejects, foreign tags,
// conflicts, redirect during a fill and reset with a transaction pending.
`ifndef XLEN
`define XLEN 32
`endif

module tb_icache_mem_ctrl;

  localparam logic [1:0] BUS_NONE = 2'h0;
  localparam logic [1:0] BUS_LOAD = 2'h1;
  localparam logic [63:0] D1 = 64'hDEADBEEF_00C0FFEE;
  localparam logic [63:0] D2 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D3 = 64'hA5A5_5A5A_0F0F_F0F0;
  localparam logic [63:0] D4 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D5 = 64'hBAD0_BAD0_BAD0_BAD0;
  localparam logic [63:0] DX = 64'hFFFF_0000_FFFF_0000;

  logic              clock;
  logic              reset;
  logic [`XLEN-1:0]  proc2Icache_addr;
  logic              proc2Icache_valid;
  logic [63:0]       Icache_data_out;
  logic              Icache_valid_out;
  logic [`XLEN-1:0]  Icache2mem_addr;
  logic [1:0]        Icache2mem_command;
  logic [3:0]        mem2Icache_response;
  logic [3:0]        mem2Icache_tag;
  logic [63:0]       mem2Icache_data;

  int checks = 0;
  int errors = 0;

  icache_mem_ctrl #(.NUM_LINES(32)) dut (
    .clock              (clock),
    .reset              (reset),
    .proc2Icache_addr   (proc2Icache_addr),
    .proc2Icache_valid  (proc2Icache_valid),
    .Icache_data_out    (Icache_data_out),
    .Icache_valid_out   (Icache_valid_out),
    .Icache2mem_addr    (Icache2mem_addr),
    .Icache2mem_command (Icache2mem_command),
    .mem2Icache_response(mem2Icache_response),
    .mem2Icache_tag     (mem2Icache_tag),
    .mem2Icache_data    (mem2Icache_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-16s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_bus(input string tag, input logic [1:0] cmd, input logic [31:0] addr);
    #1;
    chk({tag, "_cmd"}, 64'(Icache2mem_command), 64'(cmd));
    chk({tag, "_addr"}, 64'(Icache2mem_addr), 64'(addr));
  endtask

  task automatic chk_hit(input string tag, input logic vld, input logic [63:0] data);
    #1;
    chk({tag, "_vld"}, 64'(Icache_valid_out), 64'(vld));
    chk({tag, "_data"}, Icache_data_out, data);
  endtask

  initial begin
    reset = 1'b0;
    proc2Icache_addr = '0;
    proc2Icache_valid = 1'b0;
    mem2Icache_response = 4'd0;
    mem2Icache_tag = 4'd0;
    mem2Icache_data = 64'd0;

    // Reset state
    tick();
    chk_bus("rst", BUS_NONE, 32'h0);
    chk_hit("rst", 1'b0, 64'd0);
    tick();
    reset = 1'b1;

    // Basic miss and fill of 0x100
    tick();
    proc2Icache_addr = 32'h100; proc2Icache_valid = 1'b1;
    chk_hit("t1_miss", 1'b0, 64'd0);
    chk_bus("t1_idle", BUS_NONE, 32'h0);
    tick();
    chk_bus("t1_req", BUS_LOAD, 32'h100);
    mem2Icache_response = 4'd3;
    tick();
    mem2Icache_response = 4'd0;
    chk_bus("t1_wait", BUS_NONE, 32'h0);
    tick();
    mem2Icache_tag = 4'd3; mem2Icache_data = D1;
    chk_hit("t1_nobypass", 1'b0, 64'd0);
    tick();
    mem2Icache_tag = 4'd0; mem2Icache_data = 64'd0;
    chk_hit("t1_hit", 1'b1, D1);

    // Conflict miss on 0x000 with four arbiter rejections
    proc2Icache_addr = 32'h000;
    chk_hit("t4_conflict", 1'b0, 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_bus("t2_reject", BUS_LOAD, 32'h000);
    end
    tick();
    mem2Icache_response = 4'd5;
    chk_bus("t2_accept", BUS_LOAD, 32'h000);
    tick();
    mem2Icache_response = 4'd0;
    chk_bus("t2_wait", BUS_NONE, 32'h0);

    // Foreign tag ignored, matching tag fills
    mem2Icache_tag = 4'd2; mem2Icache_data = DX;
    tick();
    mem2Icache_tag = 4'd0;
    chk_hit("t3_foreign", 1'b0, 64'd0);
    chk_bus("t3_still_wait", BUS_NONE, 32'h0);
    mem2Icache_tag = 4'd5; mem2Icache_data = D2;
    tick();
    mem2Icache_tag = 4'd0;
    chk_hit("t3_fill", 1'b1, D2);

    // 0x100 was evicted: refill it
    proc2Icache_addr = 32'h100;
    chk_hit("t4_evicted", 1'b0, 64'd0);
    tick();
    chk_bus("t4_req", BUS_LOAD, 32'h100);
    mem2Icache_response = 4'd4;
    tick();
    mem2Icache_response = 4'd0;
    mem2Icache_tag = 4'd4; mem2Icache_data = D3;
    tick();
    mem2Icache_tag = 4'd0;
    chk_hit("t4_refill", 1'b1, D3);

    // Redirect: miss 0x000, then PC moves while the fill is outstanding
    proc2Icache_addr = 32'h000;
    chk_hit("t5_miss", 1'b0, 64'd0);
    tick();
    chk_bus("t5_req", BUS_LOAD, 32'h000);
    mem2Icache_response = 4'd6;
    tick();
    mem2Icache_response = 4'd0;
    proc2Icache_addr = 32'h100;
    chk_hit("t5_redirect_hit", 1'b1, D3);
    tick();
    proc2Icache_addr = 32'h208;
    chk_hit("t5_newmiss", 1'b0, 64'd0);
    chk_bus("t5_notlatched", BUS_NONE, 32'h0);
    tick();
    proc2Icache_addr = 32'h000;
    mem2Icache_tag = 4'd6; mem2Icache_data = D4;
    chk_hit("t5_fillcyc", 1'b0, 64'd0);
    tick();
    mem2Icache_tag = 4'd0;
    chk_hit("t5_filled", 1'b1, D4);

    // Back-to-back miss, then reset with tag 7 pending
    proc2Icache_addr = 32'h100;
    chk_hit("t6_miss", 1'b0, 64'd0);
    tick();
    chk_bus("t6_req", BUS_LOAD, 32'h100);
    mem2Icache_response = 4'd7;
    tick();
    mem2Icache_response = 4'd0;
    proc2Icache_valid = 1'b0;
    reset = 1'b0;
    chk_bus("t6_in_reset", BUS_NONE, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    mem2Icache_tag = 4'd7; mem2Icache_data = D5;
    chk_bus("t6_idle", BUS_NONE, 32'h0);
    tick();
    mem2Icache_tag = 4'd0;
    proc2Icache_valid = 1'b1;
    proc2Icache_addr = 32'h100;
    chk_hit("t6_stale_tag", 1'b0, 64'd0);
    proc2Icache_addr = 32'h000;
    chk_hit("t6_cleared", 1'b0, 64'd0);
    tick();
    chk_bus("t6_newreq", BUS_LOAD, 32'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
